// File: rtl/test_engine_nic_output_arbiter.sv
// Round-robin arbiter/sequencer for a shared NIC output channel with credit flow control.
// Optional macro NIC_ARB_BACK_TO_BACK_EN: chain the next grant from the last flit cycle.
module test_engine_nic_output_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CREDITS    = 2,
    parameter int DATA_FLITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_din,
    input  logic               credit_in_din,
    output logic [NUM_REQ-1:0] grant_dout,
    output logic               flit_valid_dout,
    output logic [2:0]         flit_select_dout,
    output logic [NUM_REQ-1:0] done_ack_dout,
    output logic               zero_credits_dout,
    output logic               busy_dout
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CRD_W = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CRD_W-1:0]   credits;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               win_found;
    logic               grant_take;
    logic               credit_ok;

    // In SEND the current winner is excluded so a chained grant always moves on.
    assign arb_req   = (state == SEND) ? (req_din & ~grant_dout) : req_din;
    assign credit_ok = (credits != '0);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && arb_req[PTR_W'((32'(rr_ptr) + i) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;
    assign next_ptr   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef NIC_ARB_BACK_TO_BACK_EN
    assign grant_take = credit_ok && win_found &&
                        ((state == ARB) || ((state == SEND) && (flit_select_dout == 3'd0)));
`else
    assign grant_take = credit_ok && win_found && (state == ARB);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            credits          <= CRD_W'(CREDITS);
            rr_ptr           <= '0;
            grant_dout       <= '0;
            flit_valid_dout  <= 1'b0;
            flit_select_dout <= '0;
            done_ack_dout    <= '0;
        end else begin
            done_ack_dout <= '0;

            if (grant_take && !credit_in_din)
                credits <= credits - 1'b1;
            else if (!grant_take && credit_in_din && (credits != CRD_W'(CREDITS)))
                credits <= credits + 1'b1;

            if (grant_take) begin
                state            <= SEND;
                rr_ptr           <= next_ptr;
                grant_dout       <= win_onehot;
                flit_valid_dout  <= 1'b1;
                flit_select_dout <= 3'(DATA_FLITS);
            end else begin
                case (state)
                    IDLE: if (|req_din) state <= ARB;
                    ARB:  if (req_din == '0) state <= IDLE;
                    SEND: begin
                        if (flit_select_dout == 3'd0) begin
                            state           <= IDLE;
                            grant_dout      <= '0;
                            flit_valid_dout <= 1'b0;
                        end else begin
                            flit_select_dout <= flit_select_dout - 1'b1;
                            // Registered ack lands in the same cycle as select==0.
                            if (flit_select_dout == 3'd1)
                                done_ack_dout <= grant_dout;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign zero_credits_dout = (credits == '0);
    assign busy_dout         = (state != IDLE);

endmodule
